// File: rtl/usb_fs_out_xfer_ctrl.sv
// USB full-speed OUT/SETUP transaction sequencer.
// Claims one OUT endpoint per token, forwards payload minus CRC16, picks the handshake.
module usb_fs_out_xfer_ctrl #(
    parameter int NUM_OUT_EP = 2,
    parameter int MAX_PKT    = 64,
    parameter int RX_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            dev_addr,
    input  logic                  rx_pkt_start,
    input  logic                  rx_pkt_end,
    input  logic [3:0]            rx_pid,
    input  logic [6:0]            rx_addr,
    input  logic [3:0]            rx_endp,
    input  logic                  rx_valid_packet,
    input  logic                  rx_data_put,
    input  logic [7:0]            rx_data,
    input  logic [NUM_OUT_EP-1:0] ep_enable,
    input  logic [NUM_OUT_EP-1:0] ep_stall,
    input  logic [NUM_OUT_EP-1:0] ep_ready,
    output logic [NUM_OUT_EP-1:0] ep_put,
    output logic [7:0]            ep_data,
    output logic [NUM_OUT_EP-1:0] ep_setup,
    output logic [NUM_OUT_EP-1:0] ep_commit,
    output logic [NUM_OUT_EP-1:0] ep_discard,
    output logic                  hs_req,
    output logic [3:0]            hs_pid,
    input  logic                  hs_grant,
    output logic                  busy
);

    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int CW = $clog2(MAX_PKT + 2);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        DATA_RX,
        HANDSHAKE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_OUT_EP-1:0] ep_sel_q, ep_sel_d;
    logic                  is_setup_q, is_setup_d;
    logic [NUM_OUT_EP-1:0] toggle_q, toggle_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            dly0_q, dly0_d;
    logic [7:0]            dly1_q, dly1_d;
    logic [1:0]            held_q, held_d;
    logic [NUM_OUT_EP-1:0] ep_put_q, ep_put_d;
    logic [7:0]            ep_data_q, ep_data_d;
    logic [NUM_OUT_EP-1:0] ep_setup_q, ep_setup_d;
    logic [NUM_OUT_EP-1:0] ep_commit_q, ep_commit_d;
    logic [NUM_OUT_EP-1:0] ep_discard_q, ep_discard_d;
    logic                  hs_req_q, hs_req_d;
    logic [3:0]            hs_pid_q, hs_pid_d;

    logic [NUM_OUT_EP-1:0] tok_sel;
    logic                  tok_ok;
    logic                  cur_ready;
    logic                  cur_stall;
    logic                  cur_tog;
    logic                  data_ok;

    // Decode the ending token and select the addressed endpoint (none if out of range).
    always_comb begin
        tok_sel = '0;
        for (int i = 0; i < NUM_OUT_EP; i++) begin
            tok_sel[i] = (rx_endp == 4'(i));
        end
        tok_ok = rx_pkt_end && rx_valid_packet
              && (rx_pid == PID_OUT || rx_pid == PID_SETUP)
              && (rx_addr == dev_addr)
              && |(tok_sel & ep_enable);
        cur_ready = |(ep_ready & ep_sel_q);
        cur_stall = |(ep_stall & ep_sel_q);
        cur_tog   = |(toggle_q & ep_sel_q);
        data_ok   = rx_valid_packet
                 && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1);
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        ep_sel_d     = ep_sel_q;
        is_setup_d   = is_setup_q;
        toggle_d     = toggle_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        dly0_d       = dly0_q;
        dly1_d       = dly1_q;
        held_d       = held_q;
        ep_put_d     = '0;
        ep_data_d    = ep_data_q;
        ep_commit_d  = '0;
        ep_discard_d = '0;
        hs_req_d     = hs_req_q;
        hs_pid_d     = hs_pid_q;

        unique case (state_q)
            IDLE: begin
                if (tok_ok) begin
                    state_d    = WAIT_DATA;
                    ep_sel_d   = tok_sel;
                    is_setup_d = (rx_pid == PID_SETUP);
                    tmo_d      = '0;
                    cnt_d      = '0;
                    held_d     = '0;
                    if (rx_pid == PID_SETUP) begin
                        toggle_d = toggle_q & ~tok_sel;
                    end
                end
            end
            WAIT_DATA: begin
                if (rx_pkt_start) begin
                    state_d = DATA_RX;
                    cnt_d   = '0;
                    held_d  = '0;
                end else if (tmo_q == TW'(RX_TIMEOUT)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DATA_RX: begin
                if (rx_pkt_end) begin
                    if (!data_ok || cnt_q > CW'(MAX_PKT)) begin
                        ep_discard_d = ep_sel_q;
                        state_d      = IDLE;
                    end else if (is_setup_q) begin
                        if (rx_pid != PID_DATA0 || !cur_ready) begin
                            ep_discard_d = ep_sel_q;
                            state_d      = IDLE;
                        end else begin
                            ep_commit_d = ep_sel_q;
                            toggle_d    = toggle_q | ep_sel_q;
                            hs_req_d    = 1'b1;
                            hs_pid_d    = PID_ACK;
                            state_d     = HANDSHAKE;
                        end
                    end else begin
                        state_d  = HANDSHAKE;
                        hs_req_d = 1'b1;
                        if (cur_stall) begin
                            ep_discard_d = ep_sel_q;
                            hs_pid_d     = PID_STALL;
                        end else if (!cur_ready) begin
                            ep_discard_d = ep_sel_q;
                            hs_pid_d     = PID_NAK;
                        end else if (rx_pid[3] != cur_tog) begin
                            ep_discard_d = ep_sel_q;
                            hs_pid_d     = PID_ACK;
                        end else begin
                            ep_commit_d = ep_sel_q;
                            toggle_d    = toggle_q ^ ep_sel_q;
                            hs_pid_d    = PID_ACK;
                        end
                    end
                end else if (rx_data_put) begin
                    if (held_q == 2'd2) begin
                        ep_put_d  = ep_sel_q;
                        ep_data_d = dly1_q;
                        if (cnt_q != CW'(MAX_PKT + 1)) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        held_d = held_q + 2'd1;
                    end
                    dly1_d = dly0_q;
                    dly0_d = rx_data;
                end
            end
            HANDSHAKE: begin
                if (hs_req_q && hs_grant) begin
                    hs_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ep_setup_d = (state_d != IDLE && is_setup_d) ? ep_sel_d : '0;
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ep_sel_q     <= '0;
            is_setup_q   <= 1'b0;
            toggle_q     <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            dly0_q       <= '0;
            dly1_q       <= '0;
            held_q       <= '0;
            ep_put_q     <= '0;
            ep_data_q    <= '0;
            ep_setup_q   <= '0;
            ep_commit_q  <= '0;
            ep_discard_q <= '0;
            hs_req_q     <= 1'b0;
            hs_pid_q     <= '0;
        end else begin
            state_q      <= state_d;
            ep_sel_q     <= ep_sel_d;
            is_setup_q   <= is_setup_d;
            toggle_q     <= toggle_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            dly0_q       <= dly0_d;
            dly1_q       <= dly1_d;
            held_q       <= held_d;
            ep_put_q     <= ep_put_d;
            ep_data_q    <= ep_data_d;
            ep_setup_q   <= ep_setup_d;
            ep_commit_q  <= ep_commit_d;
            ep_discard_q <= ep_discard_d;
            hs_req_q     <= hs_req_d;
            hs_pid_q     <= hs_pid_d;
        end
    end

    assign ep_put     = ep_put_q;
    assign ep_data    = ep_data_q;
    assign ep_setup   = ep_setup_q;
    assign ep_commit  = ep_commit_q;
    assign ep_discard = ep_discard_q;
    assign hs_req     = hs_req_q;
    assign hs_pid     = hs_pid_q;
    assign busy       = (state_q != IDLE);

endmodule
